pipeline_hazard_unit: RTL and testbench

//   Producer side of the pipeline hold/kill interface for the 3-stage core (IF | EX | MW).

---
 rtl/pipeline_hazard_unit_pkg.sv | 19 +
 rtl/hazard_fwd_cmp.sv | 18 +
 rtl/pipeline_hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Purpose: shared types and defaults for the 3-stage core hazard logic (IF | EX | MW).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_unit_pkg;

    localparam int REG_ADDR_W_DEF  = 5;
    localparam int TIMEOUT_CYC_DEF = 255;

    // addi x0, x0, 0 -- loaded into IF/EX by flush consumers.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Data-bus access sequencer states.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        TMO  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Purpose: one EX source-index comparator against the MW destination for forwarding.
// Latency: combinational, same cycle.
// Backpressure: none; pure function of its inputs.
// Ports: rs_ex (EX source index), rd_mw (MW destination index),
//        wr_en (MW write will commit), hit (forward MW write-back data).
module hazard_fwd_cmp #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_ex,
    input  logic [REG_ADDR_W-1:0] rd_mw,
    input  logic                  wr_en,
    output logic                  hit
);

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    assign hit = wr_en && (rd_mw != '0) && (rd_mw == rs_ex);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Purpose: stall/flush/kill generation, EX forwarding from MW, and req/ack/timeout data-bus sequencing.
// Latency: stall, flush, fwd, mem_valid, mw_kill same cycle as inputs; bus_err one cycle after timeout detect.
// Backpressure: a pending bus access without ack holds PC, IF/EX and MW; flushes are held off while stalled.
// Ports: clk/reset (sync, active-high); rs1_ex/rs2_ex/rd_mw/reg_wr_mw register hazards;
//        mem_rd_mw/mem_wr_mw/mem_ack bus handshake; br_taken_ex/csr_ret_mw control flow;
//        stall/mem_valid/flush_ex/flush_mw/mw_kill/fwd_a/fwd_b/bus_err controls;
//        stall_cnt/flush_cnt perf counters, live only when HAZARD_PERF_CNT_EN is defined (else tied 0).
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_ex,
    input  logic [REG_ADDR_W-1:0] rs2_ex,
    input  logic [REG_ADDR_W-1:0] rd_mw,
    input  logic                  reg_wr_mw,
    input  logic                  mem_rd_mw,
    input  logic                  mem_wr_mw,
    input  logic                  mem_ack,
    input  logic                  br_taken_ex,
    input  logic                  csr_ret_mw,
    output logic                  stall,
    output logic                  mem_valid,
    output logic                  flush_ex,
    output logic                  flush_mw,
    output logic                  mw_kill,
    output logic                  fwd_a,
    output logic                  fwd_b,
    output logic                  bus_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_TMO = WCNT_W'(TIMEOUT_CYC);

    hz_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              bus_err_q, bus_err_d;
    logic              mem_req;

    assign mem_req = mem_rd_mw | mem_wr_mw;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic. wcnt counts the WAIT cycles already spent; an ack
    // on the same cycle the limit is reached still completes the access.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        bus_err_d = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d = WAIT;
                    wcnt_d  = WCNT_ONE;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_TMO) begin
                    state_d   = TMO;
                    wcnt_d    = '0;
                    bus_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_ONE;
                end
            end
            TMO:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output logic. In TMO the faulting instruction leaves MW without
    // writing back and the bus request is dropped.
    always_comb begin
        stall     = 1'b0;
        mem_valid = 1'b0;
        mw_kill   = 1'b0;
        case (state_q)
            RUN: begin
                mem_valid = mem_req;
                stall     = mem_req && !mem_ack;
            end
            WAIT: begin
                mem_valid = 1'b1;
                stall     = !mem_ack;
            end
            TMO:     mw_kill = 1'b1;
            default: ;
        endcase
    end

    assign bus_err = bus_err_q;

    // Held instructions must re-resolve their redirect on release, so
    // flushes only fire in cycles that actually advance the pipeline.
    assign flush_ex = (br_taken_ex | csr_ret_mw) & ~stall;
    assign flush_mw = csr_ret_mw & ~stall;

    logic fwd_wr_en;
    assign fwd_wr_en = reg_wr_mw & ~mw_kill;

    hazard_fwd_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_ex (rs1_ex),
        .rd_mw (rd_mw),
        .wr_en (fwd_wr_en),
        .hit   (fwd_a)
    );

    hazard_fwd_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_ex (rs2_ex),
        .rd_mw (rd_mw),
        .wr_en (fwd_wr_en),
        .hit   (fwd_b)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_ex && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Purpose: self-checking bench for pipeline_hazard_unit (TIMEOUT_CYC=4).
// Latency: per-cycle vectors, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_pipeline_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_ex, rs2_ex, rd_mw;
    logic       reg_wr_mw, mem_rd_mw, mem_wr_mw, mem_ack, br_taken_ex, csr_ret_mw;
    logic       stall, mem_valid, flush_ex, flush_mw, mw_kill, fwd_a, fwd_b, bus_err;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .REG_ADDR_W  (5),
        .TIMEOUT_CYC (4),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rs1_ex      (rs1_ex),
        .rs2_ex      (rs2_ex),
        .rd_mw       (rd_mw),
        .reg_wr_mw   (reg_wr_mw),
        .mem_rd_mw   (mem_rd_mw),
        .mem_wr_mw   (mem_wr_mw),
        .mem_ack     (mem_ack),
        .br_taken_ex (br_taken_ex),
        .csr_ret_mw  (csr_ret_mw),
        .stall       (stall),
        .mem_valid   (mem_valid),
        .flush_ex    (flush_ex),
        .flush_mw    (flush_mw),
        .mw_kill     (mw_kill),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .bus_err     (bus_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    typedef struct {
        logic       chk;
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       wr, mrd, mwr, ack, br, ret;
        logic [7:0] e;   // {stall, mem_valid, flush_ex, flush_mw, mw_kill, fwd_a, fwd_b, bus_err}
    } vec_t;

    vec_t   exp_q[$];
    vec_t   tbl[24];
    int     total  = 0;
    int     passes = 0;
    int     vidx   = 0;
    int     exp_sc = 0;
    int     exp_fc = 0;

    function automatic vec_t mk(input logic chk, input logic rst,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic wr, input logic mrd, input logic mwr, input logic ack,
                                input logic br, input logic ret, input logic [7:0] e);
        vec_t v;
        v.chk = chk; v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.wr = wr; v.mrd = mrd; v.mwr = mwr; v.ack = ack; v.br = br; v.ret = ret;
        v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, vidx, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        reset = v.rst; rs1_ex = v.rs1; rs2_ex = v.rs2; rd_mw = v.rd;
        reg_wr_mw = v.wr; mem_rd_mw = v.mrd; mem_wr_mw = v.mwr; mem_ack = v.ack;
        br_taken_ex = v.br; csr_ret_mw = v.ret;
        if (v.chk) exp_q.push_back(v);
        @(negedge clk);
        if (v.chk) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("stall",     {31'd0, stall},     {31'd0, e.e[7]});
                check("mem_valid", {31'd0, mem_valid}, {31'd0, e.e[6]});
                check("flush_ex",  {31'd0, flush_ex},  {31'd0, e.e[5]});
                check("flush_mw",  {31'd0, flush_mw},  {31'd0, e.e[4]});
                check("mw_kill",   {31'd0, mw_kill},   {31'd0, e.e[3]});
                check("fwd_a",     {31'd0, fwd_a},     {31'd0, e.e[2]});
                check("fwd_b",     {31'd0, fwd_b},     {31'd0, e.e[1]});
                check("bus_err",   {31'd0, bus_err},   {31'd0, e.e[0]});
                check("stall_cnt", stall_cnt, PERF ? 32'(exp_sc) : 32'd0);
                check("flush_cnt", flush_cnt, PERF ? 32'(exp_fc) : 32'd0);
            end
        end
        // Counters reflect the cycles before this one; reset clears them.
        if (v.rst) begin
            exp_sc = 0;
            exp_fc = 0;
        end else begin
            exp_sc += int'(v.e[7]);
            exp_fc += int'(v.e[5]);
        end
        vidx++;
    endtask

    initial begin
        reset = 1'b1; rs1_ex = '0; rs2_ex = '0; rd_mw = '0;
        reg_wr_mw = 0; mem_rd_mw = 0; mem_wr_mw = 0; mem_ack = 0;
        br_taken_ex = 0; csr_ret_mw = 0;

        //            chk rst rs1 rs2 rd wr mrd mwr ack br ret   expected
        tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000); // reset state
        tbl[3]  = mk(1, 0, 5, 5, 5, 1, 0, 0, 0, 0, 0, 8'b00000110); // fwd both
        tbl[4]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b00000000); // x0 not forwarded
        tbl[5]  = mk(1, 0, 5, 6, 6, 1, 0, 0, 0, 0, 0, 8'b00000010); // fwd b only
        tbl[6]  = mk(1, 0, 7, 7, 7, 0, 0, 0, 0, 0, 0, 8'b00000000); // no write, no fwd
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b00100000); // branch
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b00110000); // mret
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'b00110000); // both
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'b11000000); // load, RUN->WAIT
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 8'b11000000); // branch held
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 8'b11000000);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 8'b01100000); // ack: release, flush
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000); // no bus_err
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'b01000000); // zero-wait store
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000);
        tbl[17] = mk(1, 0, 9, 0, 9, 1, 1, 0, 0, 0, 0, 8'b11000100); // timeout: RUN
        tbl[18] = mk(1, 0, 9, 0, 9, 1, 1, 0, 0, 0, 0, 8'b11000100); // WAIT 1
        tbl[19] = mk(1, 0, 9, 0, 9, 1, 1, 0, 0, 0, 0, 8'b11000100); // WAIT 2
        tbl[20] = mk(1, 0, 9, 0, 9, 1, 1, 0, 0, 0, 0, 8'b11000100); // WAIT 3
        tbl[21] = mk(1, 0, 9, 0, 9, 1, 1, 0, 0, 0, 0, 8'b11000100); // WAIT 4 -> TMO
        tbl[22] = mk(1, 0, 9, 0, 9, 1, 1, 0, 0, 1, 0, 8'b00101001); // TMO
        tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000); // pulse ended

        for (int i = 0; i < 24; i++) apply(tbl[i]);

        // Ack arriving exactly when the wait count reaches the limit wins.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'b11000000));
        for (int i = 0; i < 3; i++) apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'b11000000));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'b01000000));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000));

        // Reset in the middle of a WAIT abandons the access.
        apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'b11000000));
        apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'b11000000));
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b11000000)); // still WAIT this cycle
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b00000000));

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
